// File: rtl/phase_serializer_if.sv
// Phase bus between the serializer (master) and the phase_parser bank (slave).
//   phase_data : {channel[7:0], phase[7:0]} word, meaningful only while en=1
//   en         : word valid
//   ready      : receiver accepts the current word this cycle (transfer = en && ready)
interface phase_serializer_if;
    logic [15:0] phase_data;
    logic        en;
    logic        ready;

    modport master (output phase_data, output en, input ready);
    modport slave  (input phase_data, input en, output ready);
endinterface

// File: rtl/phase_serializer.sv
// Transmit side of the per-channel phase bus. A start pulse snapshots the channel
// phases and emits one {channel, phase} word per channel in ascending order, then
// pulses done for one cycle.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : 1-cycle frame request (ignored while a frame is in progress)
//   phases    : phases[NUM_CHANNELS] of [7:0], sampled only on an accepted start
//   bus       : phase_serializer_if.master (phase_data, en out; ready in)
//   busy      : frame in progress
//   done      : 1-cycle pulse after the last word of a frame transfers
// Optional feature (macro PHASE_SERIALIZER_SKIP_UNCHANGED_EN): remember the last
// phase sent per channel and only send channels whose phase changed.
module phase_serializer #(
    parameter int NUM_CHANNELS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        phases [NUM_CHANNELS],
    phase_serializer_if.master bus,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       snap_q [NUM_CHANNELS];
    logic [7:0]       snap_d [NUM_CHANNELS];
    logic [15:0]      data_q, data_d;
    logic             en_q, en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

`ifdef PHASE_SERIALIZER_SKIP_UNCHANGED_EN
    logic [7:0]              last_q [NUM_CHANNELS];
    logic [7:0]              last_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pend_q, pend_d;
    logic [NUM_CHANNELS-1:0] dirty, rem, scan;
    logic [IDX_W-1:0]        pick;
    logic                    found;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            snap_q  <= '{default: '0};
            data_q  <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PHASE_SERIALIZER_SKIP_UNCHANGED_EN
            last_q  <= '{default: '0};
            pend_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PHASE_SERIALIZER_SKIP_UNCHANGED_EN
            last_q  <= last_d;
            pend_q  <= pend_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        data_d  = data_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = done_q;
`ifdef PHASE_SERIALIZER_SKIP_UNCHANGED_EN
        last_d  = last_q;
        pend_d  = pend_q;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            dirty[i] = (phases[i] != last_q[i]);
        end
        rem        = pend_q;
        rem[idx_q] = 1'b0;
        // One lowest-set-bit search serves both the first pick at start and the
        // next pick after each transfer.
        scan  = (state_q == IDLE) ? dirty : rem;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = NUM_CHANNELS; i > 0; i--) begin
            if (scan[i-1]) begin
                pick  = IDX_W'(i - 1);
                found = 1'b1;
            end
        end
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d = phases;
`ifdef PHASE_SERIALIZER_SKIP_UNCHANGED_EN
                    pend_d = dirty;
                    if (found) begin
                        idx_d   = pick;
                        data_d  = {8'(pick), phases[pick]};
                        en_d    = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SEND;
                    end else begin
                        // Nothing to send: FIN raises done one cycle later.
                        state_d = FIN;
                    end
`else
                    idx_d   = '0;
                    data_d  = {8'h00, phases[0]};
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                    state_d = SEND;
`endif
                end
            end

            SEND: begin
                if (en_q && bus.ready) begin
`ifdef PHASE_SERIALIZER_SKIP_UNCHANGED_EN
                    last_d[idx_q] = snap_q[idx_q];
                    pend_d        = rem;
                    if (found) begin
                        idx_d  = pick;
                        data_d = {8'(pick), snap_q[pick]};
                    end else begin
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end
`else
                    if (idx_q == LAST_IDX) begin
                        en_d    = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = FIN;
                    end else begin
                        idx_d  = idx_q + 1'b1;
                        data_d = {8'(idx_d), snap_q[idx_d]};
                    end
`endif
                end
            end

            FIN: begin
                // Entered with done already set after a sent frame; the empty-frame
                // path arrives with done clear and spends one extra cycle raising it.
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.phase_data = data_q;
    assign bus.en         = en_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
